boid_frame_writer: RTL

Double-buffered boid framebuffer sequencer. On each VGA end-of-frame pulse it clears the back buffer, then walks every boid slot. For each boid it writes a BOID_SIZE×BOID_SIZE pixel block, clipped to the screen, then swaps buffers. It sits between the BPU array (via a boid select index) and the resettable boid display RAM, and replaces the ad-hoc boid counter loop at top level.

---
 rtl/boid_frame_writer_if.sv | 34 +++
 rtl/boid_frame_writer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/boid_frame_writer_if.sv
// Boid frame writer bus: frame control, boid select and framebuffer write port.
// master = sequencer side, slave = environment side.
interface boid_frame_writer_if #(
  parameter int BOID_IDX_W = 2,
  parameter int ADDR_W     = 19
);
  logic                  enable;
  logic                  frame_end;
  logic [BOID_IDX_W-1:0] sel;
  logic [9:0]            x_in;
  logic [8:0]            y_in;
  logic                  clear_req;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic                  buf_sel;
  logic                  busy;
  logic                  done;
  logic [15:0]           frame_count;
  logic [7:0]            dropped_frames;

  modport master (
    input  enable, frame_end, x_in, y_in,
    output sel, clear_req, wr_en, wr_addr,
    output buf_sel, busy, done,
    output frame_count, dropped_frames
  );

  modport slave (
    output enable, frame_end, x_in, y_in,
    input  sel, clear_req, wr_en, wr_addr,
    input  buf_sel, busy, done,
    input  frame_count, dropped_frames
  );
endinterface

// File: rtl/boid_frame_writer.sv
// Double-buffered boid framebuffer sequencer: clear, draw clipped
// boid blocks, then swap buffers on every accepted end-of-frame.
module boid_frame_writer #(
  parameter int MAX_BOIDS    = 4,
  parameter int BOID_IDX_W   = (MAX_BOIDS > 1) ? $clog2(MAX_BOIDS) : 1,
  parameter int VIDEO_WIDTH  = 640,
  parameter int VIDEO_HEIGHT = 480,
  parameter int ADDR_W       = 19,
  parameter int BOID_SIZE    = 1
) (
  input logic              clock,
  input logic              CPU_RESETN,
  boid_frame_writer_if.master bus
);

  localparam int SW = (BOID_SIZE > 1) ? $clog2(BOID_SIZE) : 1;
  localparam logic [SW-1:0] S_LAST = SW'(BOID_SIZE - 1);
  localparam logic [BOID_IDX_W-1:0] B_LAST = BOID_IDX_W'(MAX_BOIDS - 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, DRAW, DRAIN, SWAP
  } state_e;

  state_e                state_q;
  logic [BOID_IDX_W-1:0] idx_q;
  logic [SW-1:0]         dx_q;
  logic [SW-1:0]         dy_q;
  logic                  clear_q;
  logic                  wr_en_q;
  logic [ADDR_W-1:0]     addr_q;
  logic                  buf_q;
  logic                  busy_q;
  logic                  done_q;
  logic [15:0]           fc_q;
  logic [7:0]            drop_q;

  logic [10:0]       px_d;
  logic [9:0]        py_d;
  logic              on_d;
  logic [ADDR_W-1:0] addr_d;

  assign px_d = {1'b0, bus.x_in} + 11'(dx_q);
  assign py_d = {1'b0, bus.y_in} + 10'(dy_q);
  assign on_d = (px_d < 11'(VIDEO_WIDTH)) &&
                (py_d < 10'(VIDEO_HEIGHT));
  assign addr_d = ADDR_W'(21'(py_d) * 21'(VIDEO_WIDTH)
                          + 21'(px_d));

  // Issue and write stage are fused: the pixel decision is registered
  // at issue, so wr_en/wr_addr appear one cycle after sel.
  always_ff @(posedge clock or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      clear_q <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      buf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fc_q    <= '0;
      drop_q  <= '0;
    end else begin
      clear_q <= 1'b0;
      done_q  <= 1'b0;
      if (bus.frame_end && state_q != IDLE && drop_q != 8'hFF)
        drop_q <= drop_q + 8'd1;
      unique case (state_q)
        IDLE: begin
          if (bus.enable && bus.frame_end) begin
            state_q <= CLEAR;
            clear_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          idx_q   <= '0;
          dx_q    <= '0;
          dy_q    <= '0;
          state_q <= DRAW;
        end
        DRAW: begin
          wr_en_q <= on_d;
          if (on_d) addr_q <= addr_d;
          if (dx_q == S_LAST) begin
            dx_q <= '0;
            if (dy_q == S_LAST) begin
              dy_q <= '0;
              if (idx_q == B_LAST) state_q <= DRAIN;
              else idx_q <= idx_q + 1'b1;
            end else begin
              dy_q <= dy_q + 1'b1;
            end
          end else begin
            dx_q <= dx_q + 1'b1;
          end
        end
        DRAIN: begin
          wr_en_q <= 1'b0;
          buf_q   <= ~buf_q;
          done_q  <= 1'b1;
          fc_q    <= fc_q + 16'd1;
          state_q <= SWAP;
        end
        SWAP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sel            = idx_q;
  assign bus.clear_req      = clear_q;
  assign bus.wr_en          = wr_en_q;
  assign bus.wr_addr        = addr_q;
  assign bus.buf_sel        = buf_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.frame_count    = fc_q;
  assign bus.dropped_frames = drop_q;

endmodule
